// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug/run controller.
// Contents: FSM state encoding, MODE switch encoding, debug bus widths and
// the MODE-to-state mapping used when leaving reset hold or changing mode.
package cpu_dbg_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned MODE_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RST_HOLD = 3'd0,
        ST_RUN      = 3'd1,
        ST_THROTTLE = 3'd2,
        ST_STEP     = 3'd3,
        ST_HALTED   = 3'd4,
        ST_BREAK    = 3'd5
    } state_e;

    typedef enum logic [MODE_W-1:0] {
        MODE_RUN      = 2'b00,
        MODE_THROTTLE = 2'b01,
        MODE_STEP     = 2'b10,
        MODE_HALT     = 2'b11
    } mode_e;

    // Execution state selected by the MODE switches
    function automatic state_e mode_to_state(input mode_e m);
        mode_to_state = ST_HALTED;
        case (m)
            MODE_RUN:      mode_to_state = ST_RUN;
            MODE_THROTTLE: mode_to_state = ST_THROTTLE;
            MODE_STEP:     mode_to_state = ST_STEP;
            default:       mode_to_state = ST_HALTED;
        endcase
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// CPU-side connection of the run controller.
// master: the soft CPU (drives PC and data-memory bus, receives RST_N/HALT)
// slave : the run controller (observes PC and stores, drives RST_N/HALT)
interface cpu_run_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] CPU_PC;
    logic [ADDR_W-1:0] DMEM_ADDR;
    logic [DATA_W-1:0] DMEM_DATA_OUT;
    logic              DMEM_READ_WRN;
    logic              CPU_RST_N;
    logic              CPU_HALT;

    modport master (
        output CPU_PC, DMEM_ADDR, DMEM_DATA_OUT, DMEM_READ_WRN,
        input  CPU_RST_N, CPU_HALT
    );

    modport slave (
        input  CPU_PC, DMEM_ADDR, DMEM_DATA_OUT, DMEM_READ_WRN,
        output CPU_RST_N, CPU_HALT
    );
endinterface

// File: rtl/step_sync_edge.sv
// Button synchroniser and rising-edge detector.
// Ports: clk, rst (async, active-high), btn_i (raw asynchronous button),
//        pulse_o (registered one-cycle pulse per rising edge of btn_i,
//        high on the third cycle after the pin change).
module step_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic pulse_q;

    // Two-flop synchroniser, delayed copy, and registered edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pulse_q <= sync2_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the soft RISC-V core on the debug board.
// Sequences CPU reset, gates execution (run / throttled tick / single-step /
// halt), implements a PC breakpoint and a memory-mapped LED register.
// Ports: CLK100MHZ, RST (async, active-high); MODE run-mode switches;
//        STEP_BTN raw step button; BP_EN/BP_ADDR breakpoint control;
//        bus (slave side of cpu_run_ctrl_if: PC, dmem store bus, RST_N, HALT);
//        LED register output; STATE debug encoding; BP_HIT high in BREAK.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       RST_HOLD    = 16,
    parameter int unsigned       TICK_PERIOD = 50000000,
    parameter int unsigned       NUM_LEDS    = 4,
    parameter logic [ADDR_W-1:0] LED_ADDR    = ADDR_W'(32'h0000_0001),
    parameter int unsigned       LED_MODE    = 0
) (
    input  logic                CLK100MHZ,
    input  logic                RST,
    input  logic [MODE_W-1:0]   MODE,
    input  logic                STEP_BTN,
    input  logic                BP_EN,
    input  logic [ADDR_W-1:0]   BP_ADDR,
    cpu_run_ctrl_if.slave       bus,
    output logic [NUM_LEDS-1:0] LED,
    output logic [STATE_W-1:0]  STATE,
    output logic                BP_HIT
);

    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
    localparam int unsigned TICK_W = $clog2(TICK_PERIOD);
    localparam int unsigned IDX_W  = $clog2(NUM_LEDS);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_PERIOD - 1);

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                bp_armed_q, bp_armed_d;
    logic                bp_hit_q;
    logic [NUM_LEDS-1:0] led_q, led_d;

    state_e              mode_st_c;
    logic                step_pulse_c;
    logic                bp_cmp_c;
    logic                brk_exit_c;
    logic                halt_c;
    logic                led_we_c;
    logic [NUM_LEDS-1:0] led_dec_c;
    logic [DATA_W-1:0]   unused_data;

    step_sync_edge u_step_sync (
        .clk     (CLK100MHZ),
        .rst     (RST),
        .btn_i   (STEP_BTN),
        .pulse_o (step_pulse_c)
    );

    assign mode_st_c = mode_to_state(mode_e'(MODE));
    assign bp_cmp_c  = BP_EN && bp_armed_q && (bus.CPU_PC == BP_ADDR);

    // Next state, halt gating and breakpoint arming
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        tick_d      = '0;
        cpu_rst_n_d = cpu_rst_n_q;
        bp_armed_d  = bp_armed_q;
        halt_c      = 1'b1;
        brk_exit_c  = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                hold_d = hold_q + HOLD_W'(1);
                if (hold_q == HOLD_LAST) begin
                    cpu_rst_n_d = 1'b1;
                    state_d     = mode_st_c;
                end
            end
            ST_RUN: begin
                halt_c  = 1'b0;
                state_d = mode_st_c;
            end
            ST_THROTTLE: begin
                state_d = mode_st_c;
                // A tick coinciding with a mode change is dropped
                if (mode_st_c == ST_THROTTLE) begin
                    tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
                    halt_c = (tick_q != TICK_LAST);
                end
            end
            ST_STEP: begin
                state_d = mode_st_c;
                if (mode_st_c == ST_STEP && step_pulse_c) begin
                    halt_c = 1'b0;
                end
            end
            ST_HALTED: begin
                state_d = mode_st_c;
            end
            ST_BREAK: begin
                if (mode_st_c == ST_HALTED) begin
                    state_d    = ST_HALTED;
                    brk_exit_c = 1'b1;
                end else if (step_pulse_c) begin
                    halt_c     = 1'b0;
                    state_d    = mode_st_c;
                    brk_exit_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_RST_HOLD;
            end
        endcase

        // Breakpoint holds the matching instruction in the same cycle
        if ((state_q inside {ST_RUN, ST_THROTTLE, ST_STEP}) && bp_cmp_c) begin
            halt_c  = 1'b1;
            state_d = ST_BREAK;
            tick_d  = '0;
        end

        // Disarm on leaving BREAK; re-arm once PC moves off the breakpoint
        if (brk_exit_c) begin
            bp_armed_d = 1'b0;
        end else if (!BP_EN || (bus.CPU_PC != BP_ADDR)) begin
            bp_armed_d = 1'b1;
        end
    end

    // LED data decode
    generate
        if (LED_MODE == 0) begin : g_onehot
            assign led_dec_c = NUM_LEDS'(1) << bus.DMEM_DATA_OUT[IDX_W-1:0];
        end else begin : g_bitmap
            assign led_dec_c = bus.DMEM_DATA_OUT[NUM_LEDS-1:0];
        end
    endgenerate

    // Only bits selected by the decode reach the LED register
    assign unused_data = bus.DMEM_DATA_OUT;

    assign led_we_c = cpu_rst_n_q && !bus.DMEM_READ_WRN && (bus.DMEM_ADDR == LED_ADDR);
    assign led_d    = led_we_c ? led_dec_c : led_q;

    // State and datapath registers
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RST_HOLD;
            hold_q      <= '0;
            tick_q      <= '0;
            cpu_rst_n_q <= 1'b0;
            bp_armed_q  <= 1'b1;
            bp_hit_q    <= 1'b0;
            led_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tick_q      <= tick_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            bp_armed_q  <= bp_armed_d;
            bp_hit_q    <= (state_d == ST_BREAK);
            led_q       <= led_d;
        end
    end

    assign bus.CPU_RST_N = cpu_rst_n_q;
    assign bus.CPU_HALT  = halt_c;
    assign LED           = led_q;
    assign STATE         = state_q;
    assign BP_HIT        = bp_hit_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: two instances (one-hot and bitmap LED decode) share
// stimulus; expectations come from cycle counts and the run-mode rules.
module tb_cpu_run_ctrl;

    localparam int unsigned HOLD = 16;
    localparam int unsigned TP   = 8;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        step_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] daddr;
    logic [31:0] ddata;
    logic        drw;
    logic [3:0]  led0, led1;
    logic [2:0]  st0, st1;
    logic        hit0, hit1;

    logic [3:0]  exp_led0, exp_led1;
    int          total;
    int          bad;

    cpu_run_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    cpu_run_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    assign bus0.CPU_PC        = pc;
    assign bus0.DMEM_ADDR     = daddr;
    assign bus0.DMEM_DATA_OUT = ddata;
    assign bus0.DMEM_READ_WRN = drw;
    assign bus1.CPU_PC        = pc;
    assign bus1.DMEM_ADDR     = daddr;
    assign bus1.DMEM_DATA_OUT = ddata;
    assign bus1.DMEM_READ_WRN = drw;

    cpu_run_ctrl #(
        .ADDR_W(32), .DATA_W(32), .RST_HOLD(HOLD), .TICK_PERIOD(TP),
        .NUM_LEDS(4), .LED_ADDR(32'h1), .LED_MODE(0)
    ) dut0 (
        .CLK100MHZ(clk), .RST(rst), .MODE(mode), .STEP_BTN(step_btn),
        .BP_EN(bp_en), .BP_ADDR(bp_addr), .bus(bus0),
        .LED(led0), .STATE(st0), .BP_HIT(hit0)
    );

    cpu_run_ctrl #(
        .ADDR_W(32), .DATA_W(32), .RST_HOLD(HOLD), .TICK_PERIOD(TP),
        .NUM_LEDS(4), .LED_ADDR(32'h1), .LED_MODE(1)
    ) dut1 (
        .CLK100MHZ(clk), .RST(rst), .MODE(mode), .STEP_BTN(step_btn),
        .BP_EN(bp_en), .BP_ADDR(bp_addr), .bus(bus1),
        .LED(led1), .STATE(st1), .BP_HIT(hit1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to just after the next rising edge, where inputs are driven
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold sequence after RST release; entered just after RST drops
    task automatic test_hold_sequence(input logic [2:0] exp_st);
        for (int n = 1; n <= int'(HOLD) + 3; n++) begin
            daddr = 32'h1;
            ddata = $urandom;
            drw   = (n > int'(HOLD)) ? 1'b1 : 1'b0;
            @(negedge clk);
            total++; if (bus0.CPU_RST_N !== (n > int'(HOLD))) begin bad++; $display("FAIL hold_rst_n cycle=%0d got=%b exp=%b", n, bus0.CPU_RST_N, (n > int'(HOLD))); end
            total++; if (bus0.CPU_HALT !== ((n <= int'(HOLD)) || exp_st != 3'd1)) begin bad++; $display("FAIL hold_halt cycle=%0d got=%b", n, bus0.CPU_HALT); end
            total++; if (st0 !== ((n > int'(HOLD)) ? exp_st : 3'd0)) begin bad++; $display("FAIL hold_state cycle=%0d got=%0d", n, st0); end
            total++; if (st1 !== ((n > int'(HOLD)) ? exp_st : 3'd0)) begin bad++; $display("FAIL hold_state1 cycle=%0d got=%0d", n, st1); end
            total++; if (led0 !== 4'b0 || led1 !== 4'b0) begin bad++; $display("FAIL hold_led cycle=%0d got=%b/%b exp=0000", n, led0, led1); end
            next_cycle();
        end
        drw = 1'b1;
    endtask

    task automatic test_reset();
        mode = 2'b00; step_btn = 1'b0; bp_en = 1'b0; bp_addr = 32'h0;
        pc = 32'h0; daddr = 32'h0; ddata = 32'h0; drw = 1'b1;
        rst = 1'b1;
        #2;
        total++; if (st0 !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", st0); end
        total++; if (led0 !== 4'b0 || led1 !== 4'b0) begin bad++; $display("FAIL rst_led got=%b/%b exp=0000", led0, led1); end
        total++; if (hit0 !== 1'b0 || hit1 !== 1'b0) begin bad++; $display("FAIL rst_bp_hit got=%b/%b exp=0", hit0, hit1); end
        total++; if (bus0.CPU_RST_N !== 1'b0 || bus1.CPU_RST_N !== 1'b0) begin bad++; $display("FAIL rst_cpu_rst_n got=%b exp=0", bus0.CPU_RST_N); end
        total++; if (bus0.CPU_HALT !== 1'b1 || bus1.CPU_HALT !== 1'b1) begin bad++; $display("FAIL rst_halt got=%b exp=1", bus0.CPU_HALT); end
        next_cycle();
        next_cycle();
        rst = 1'b0;
        test_hold_sequence(3'd1);
        exp_led0 = 4'b0;
        exp_led1 = 4'b0;
    endtask

    task automatic test_breakpoint();
        int bp;
        int w;
        bp = int'($urandom_range(3, 12));
        bp_addr = 32'(bp);
        bp_en = 1'b1;
        pc = 32'h0;
        // One instruction retires per cycle until the breakpoint PC
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            total++; if (bus0.CPU_HALT !== 1'b0 || st0 !== 3'd1) begin bad++; $display("FAIL bp_run pc=%0d halt=%b state=%0d exp halt=0 state=1", pc, bus0.CPU_HALT, st0); end
            next_cycle();
            pc = pc + 32'h1;
        end
        // Store in the hit cycle must still land in the LED register
        daddr = 32'h1; ddata = 32'h3; drw = 1'b0;
        @(negedge clk);
        total++; if (bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL bp_same_cycle_halt got=%b exp=1", bus0.CPU_HALT); end
        total++; if (hit0 !== 1'b0 || st0 !== 3'd1) begin bad++; $display("FAIL bp_hit_cycle state=%0d hit=%b exp state=1 hit=0", st0, hit0); end
        next_cycle();
        drw = 1'b1;
        exp_led0 = 4'b1000;
        exp_led1 = 4'b0011;
        w = int'($urandom_range(2, 5));
        for (int c = 0; c < w; c++) begin
            @(negedge clk);
            total++; if (st0 !== 3'd5 || hit0 !== 1'b1 || bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL bp_break state=%0d hit=%b halt=%b exp 5/1/1", st0, hit0, bus0.CPU_HALT); end
            total++; if (led0 !== exp_led0 || led1 !== exp_led1) begin bad++; $display("FAIL bp_store_led got=%b/%b exp=%b/%b", led0, led1, exp_led0, exp_led1); end
            next_cycle();
        end
        // Press: exactly one release three cycles later, then back to RUN
        step_btn = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            total++; if (bus0.CPU_HALT !== (c != 3)) begin bad++; $display("FAIL bp_step_release c=%0d got=%b exp=%b", c, bus0.CPU_HALT, (c != 3)); end
            total++; if (st0 !== 3'd5 || hit0 !== 1'b1) begin bad++; $display("FAIL bp_step_state c=%0d state=%0d hit=%b exp 5/1", c, st0, hit0); end
            next_cycle();
        end
        pc = pc + 32'h1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++; if (bus0.CPU_HALT !== 1'b0 || st0 !== 3'd1 || hit0 !== 1'b0) begin bad++; $display("FAIL bp_no_rehit pc=%0d halt=%b state=%0d hit=%b", pc, bus0.CPU_HALT, st0, hit0); end
            next_cycle();
            pc = pc + 32'h1;
        end
        step_btn = 1'b0;
        // Jump back onto the breakpoint: re-armed, so it hits again
        pc = bp_addr;
        @(negedge clk);
        total++; if (bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL bp_rehit_halt got=%b exp=1", bus0.CPU_HALT); end
        next_cycle();
        mode = 2'b11;
        @(negedge clk);
        total++; if (st0 !== 3'd5 || bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL bp_rehit_state got=%0d halt=%b exp 5/1", st0, bus0.CPU_HALT); end
        next_cycle();
        @(negedge clk);
        total++; if (st0 !== 3'd4 || hit0 !== 1'b0 || bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL bp_exit_halt state=%0d hit=%b halt=%b exp 4/0/1", st0, hit0, bus0.CPU_HALT); end
        bp_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_led();
        for (int i = 0; i < 40; i++) begin
            case (i)
                0:       begin daddr = 32'h1; ddata = 32'h2; drw = 1'b0; end
                1:       begin daddr = 32'h1; ddata = 32'hA; drw = 1'b0; end
                2:       begin daddr = 32'h2; ddata = 32'h5; drw = 1'b0; end
                3:       begin daddr = 32'h5; ddata = 32'h1; drw = 1'b1; end
                default: begin
                    daddr = 32'($urandom_range(0, 2));
                    ddata = $urandom;
                    drw   = 1'($urandom_range(0, 1));
                end
            endcase
            @(negedge clk);
            total++; if (led0 !== exp_led0) begin bad++; $display("FAIL led_onehot i=%0d got=%b exp=%b", i, led0, exp_led0); end
            total++; if (led1 !== exp_led1) begin bad++; $display("FAIL led_bitmap i=%0d got=%b exp=%b", i, led1, exp_led1); end
            if (!drw && daddr == 32'h1) begin
                exp_led0 = 4'b0001 << ddata[1:0];
                exp_led1 = ddata[3:0];
            end
            next_cycle();
        end
        drw = 1'b1;
    endtask

    task automatic test_throttle();
        int periods;
        int last;
        mode = 2'b01;
        @(negedge clk);
        total++; if (st0 !== 3'd4 || bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL thr_pre state=%0d halt=%b exp 4/1", st0, bus0.CPU_HALT); end
        next_cycle();
        periods = int'($urandom_range(2, 4));
        last = (periods + 1) * int'(TP);
        // k counts cycles in THROTTLE; a step is due every TP-th cycle
        for (int k = 1; k <= last; k++) begin
            if (k == last) mode = 2'b10;
            @(negedge clk);
            total++; if (bus0.CPU_HALT !== ((k % int'(TP) != 0) || k == last)) begin bad++; $display("FAIL thr_tick k=%0d got=%b exp=%b", k, bus0.CPU_HALT, ((k % int'(TP) != 0) || k == last)); end
            total++; if (st0 !== 3'd2) begin bad++; $display("FAIL thr_state k=%0d got=%0d exp=2", k, st0); end
            next_cycle();
        end
        @(negedge clk);
        total++; if (st0 !== 3'd3 || bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL thr_to_step state=%0d halt=%b exp 3/1", st0, bus0.CPU_HALT); end
        next_cycle();
    endtask

    task automatic test_step();
        int hold;
        int gap;
        for (int p = 0; p < 3; p++) begin
            hold = (p == 0) ? 20 : int'($urandom_range(1, 10));
            gap  = int'($urandom_range(4, 8));
            step_btn = 1'b1;
            for (int c = 0; c < hold + gap; c++) begin
                if (c == hold) step_btn = 1'b0;
                @(negedge clk);
                total++; if (bus0.CPU_HALT !== (c != 3)) begin bad++; $display("FAIL step_pulse p=%0d c=%0d got=%b exp=%b", p, c, bus0.CPU_HALT, (c != 3)); end
                total++; if (st0 !== 3'd3) begin bad++; $display("FAIL step_state p=%0d c=%0d got=%0d exp=3", p, c, st0); end
                next_cycle();
            end
        end
        // Step pulse arriving with a mode change is dropped
        step_btn = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c == 3) mode = 2'b11;
            @(negedge clk);
            total++; if (bus0.CPU_HALT !== 1'b1 || st0 !== ((c < 4) ? 3'd3 : 3'd4)) begin bad++; $display("FAIL step_discard c=%0d halt=%b state=%0d", c, bus0.CPU_HALT, st0); end
            next_cycle();
        end
        step_btn = 1'b0;
    endtask

    task automatic test_async_reset();
        int w;
        daddr = 32'h1; ddata = 32'h1; drw = 1'b0;
        mode = 2'b01;
        next_cycle();
        drw = 1'b1;
        w = int'($urandom_range(3, 10));
        for (int c = 0; c < w; c++) next_cycle();
        @(negedge clk);
        total++; if (led0 !== 4'b0010 || led1 !== 4'b0001) begin bad++; $display("FAIL arst_pre_led got=%b/%b exp=0010/0001", led0, led1); end
        next_cycle();
        #2;
        rst = 1'b1;
        #1;
        total++; if (led0 !== 4'b0 || led1 !== 4'b0) begin bad++; $display("FAIL arst_led got=%b/%b exp=0000", led0, led1); end
        total++; if (st0 !== 3'd0 || hit0 !== 1'b0) begin bad++; $display("FAIL arst_state got=%0d hit=%b exp 0/0", st0, hit0); end
        total++; if (bus0.CPU_RST_N !== 1'b0 || bus0.CPU_HALT !== 1'b1) begin bad++; $display("FAIL arst_cpu rst_n=%b halt=%b exp 0/1", bus0.CPU_RST_N, bus0.CPU_HALT); end
        next_cycle();
        rst = 1'b0;
        test_hold_sequence(3'd2);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_breakpoint();
        test_led();
        test_throttle();
        test_step();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
